// File: rtl/conv_mem_host.sv
// Memory host for a convolution accelerator: image store, five layer banks, run FSM.
// Combinational read ports, registered handshake, readback, write counting and a sticky error flag.
module conv_mem_host (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [11:0]        ld_addr,
    input  logic [19:0]        ld_data,
    input  logic               start,
    output logic               ready,
    input  logic               busy,
    input  logic [11:0]        iaddr,
    output logic signed [19:0] idata,
    input  logic               crd,
    input  logic [11:0]        caddr_rd,
    output logic [19:0]        cdata_rd,
    input  logic               cwr,
    input  logic [11:0]        caddr_wr,
    input  logic [19:0]        cdata_wr,
    input  logic [2:0]         csel,
    output logic               done,
    input  logic               rb_en,
    input  logic [2:0]         rb_sel,
    input  logic [11:0]        rb_addr,
    output logic [19:0]        rb_data,
    output logic               rb_valid,
    output logic [13:0]        wr_cnt,
    output logic               err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [13:0] CNT_MAX = 14'h3fff;

    logic [1:0]  state, state_n;
    logic        busy_q;

    logic [19:0] image [4096];
    logic [19:0] l0k0  [4096];
    logic [19:0] l0k1  [4096];
    logic [19:0] l1k0  [1024];
    logic [19:0] l1k1  [1024];
    logic [19:0] l2    [2048];

    logic        is_open, is_run, enter_arm;
    logic        ld_ok, wr_ok, rd_ok, rb_ok, err_evt;
    logic [19:0] rb_word;

    // Select 0 addresses the image; it is legal for readback only.
    function automatic logic loc_ok(input logic [2:0] sel, input logic [11:0] addr);
        case (sel)
            3'd0, 3'd1, 3'd2: loc_ok = 1'b1;
            3'd3, 3'd4:       loc_ok = (addr[11:10] == 2'b00);
            3'd5:             loc_ok = !addr[11];
            default:          loc_ok = 1'b0;
        endcase
    endfunction

    assign is_open   = (state == S_IDLE) || (state == S_DONE);
    assign is_run    = (state == S_RUN);
    assign ld_ok     = ld_en && is_open;
    assign wr_ok     = cwr && is_run && (csel != 3'd0) && loc_ok(csel, caddr_wr);
    assign rd_ok     = crd && (csel != 3'd0) && loc_ok(csel, caddr_rd);
    assign rb_ok     = loc_ok(rb_sel, rb_addr);
    assign err_evt   = (ld_en && !is_open) || (cwr && !wr_ok) || (crd && !rd_ok)
                     || (rb_en && is_open && !rb_ok);
    assign enter_arm = (state_n == S_ARM) && (state != S_ARM);

    assign idata = image[iaddr];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_ARM;
            S_ARM:   if (busy) state_n = S_RUN;
            S_RUN:   if (busy_q && !busy) state_n = S_DONE;
            S_DONE:  if (start) state_n = S_ARM;
            default: state_n = S_IDLE;
        endcase
    end

    // A same-cycle write lands at the edge, so this read still sees the old word.
    always_comb begin
        cdata_rd = '0;
        if (rd_ok) begin
            case (csel)
                3'd1:    cdata_rd = l0k0[caddr_rd];
                3'd2:    cdata_rd = l0k1[caddr_rd];
                3'd3:    cdata_rd = l1k0[caddr_rd[9:0]];
                3'd4:    cdata_rd = l1k1[caddr_rd[9:0]];
                3'd5:    cdata_rd = l2[caddr_rd[10:0]];
                default: cdata_rd = '0;
            endcase
        end
    end

    always_comb begin
        rb_word = '0;
        case (rb_sel)
            3'd0:    rb_word = image[rb_addr];
            3'd1:    rb_word = l0k0[rb_addr];
            3'd2:    rb_word = l0k1[rb_addr];
            3'd3:    rb_word = l1k0[rb_addr[9:0]];
            3'd4:    rb_word = l1k1[rb_addr[9:0]];
            3'd5:    rb_word = l2[rb_addr[10:0]];
            default: rb_word = '0;
        endcase
    end

    // NOTE: memories carry no reset; contents survive reset and stay mappable to RAM macros.
    always_ff @(posedge clk) begin
        if (ld_ok) image[ld_addr] <= ld_data;
        if (wr_ok) begin
            case (csel)
                3'd1:    l0k0[caddr_wr]       <= cdata_wr;
                3'd2:    l0k1[caddr_wr]       <= cdata_wr;
                3'd3:    l1k0[caddr_wr[9:0]]  <= cdata_wr;
                3'd4:    l1k1[caddr_wr[9:0]]  <= cdata_wr;
                3'd5:    l2[caddr_wr[10:0]]   <= cdata_wr;
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            ready    <= 1'b0;
            done     <= 1'b0;
            rb_valid <= 1'b0;
            rb_data  <= '0;
            wr_cnt   <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            busy_q   <= busy;
            ready    <= (state_n == S_ARM);
            done     <= (state_n == S_DONE);
            rb_valid <= rb_en && is_open;
            if (rb_en && is_open) rb_data <= rb_ok ? rb_word : '0;

            if (enter_arm)
                wr_cnt <= '0;
            else if (wr_ok && (wr_cnt != CNT_MAX))
                wr_cnt <= wr_cnt + 14'd1;

            err <= (enter_arm ? 1'b0 : err) | err_evt;
        end
    end

endmodule

// File: doc/conv_mem_host.md
CONV_MEM_HOST -- requirements
Module: conv_mem_host

Interface
REQ-001 SHALL have clk, input, 1: clock, all state updates on posedge.
REQ-002 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have ld_en/ld_addr/ld_data, inputs, 1/12/20: image loader write port.
REQ-004 SHALL have start, input, 1: begin one accelerator run.
REQ-005 SHALL have ready, output, 1: run request to accelerator.
REQ-006 SHALL have busy, input, 1: accelerator activity flag.
REQ-007 SHALL have iaddr, input, 12, and idata, output, 20 signed: image read port.
REQ-008 SHALL have crd, input, 1; caddr_rd, input, 12; cdata_rd, output, 20: layer read port.
REQ-009 SHALL have cwr, input, 1; caddr_wr, input, 12; cdata_wr, input, 20: layer write port.
REQ-010 SHALL have csel, input, 3: bank select for both layer ports.
REQ-011 SHALL have done, output, 1: run complete.
REQ-012 SHALL have rb_en/rb_sel/rb_addr, inputs, 1/3/12, and rb_data/rb_valid, outputs, 20/1: readback port.
REQ-013 SHALL have wr_cnt, output, 14, and err, output, 1: accepted-write count, sticky error.

Function
REQ-014 SHALL hold image memory 4096x20; banks: csel 1 = L0 kernel0 (4096), 2 = L0 kernel1 (4096), 3 = L1 kernel0 (1024), 4 = L1 kernel1 (1024), 5 = L2 (2048).
REQ-015 SHALL write ld_data to image[ld_addr] on posedge when ld_en=1 and state is IDLE or DONE; ld_en in ARM/RUN: write dropped, err set.
REQ-016 SHALL drive idata combinationally = image[iaddr], every cycle, no latency.
REQ-017 SHALL drive cdata_rd combinationally = bank[csel][caddr_rd] when crd=1, else 0.
REQ-018 SHALL write cdata_wr to bank[csel][caddr_wr] on posedge when cwr=1 and state is RUN.
REQ-019 Same-cycle cwr and crd to same bank/address: cdata_rd SHALL return pre-write contents.
REQ-020 csel in {0,6,7} or address >= bank depth: write dropped, read returns 0, err set.
REQ-021 cwr while not RUN: write dropped, err set.
REQ-022 wr_cnt SHALL increment per accepted write, saturating at 16383; cleared on entering ARM.
REQ-023 SHALL implement FSM IDLE, ARM, RUN, DONE.
REQ-024 IDLE: start=1 -> ARM.
REQ-025 ARM: ready=1; busy sampled 1 -> RUN, ready=0 in RUN.
REQ-026 RUN: busy sampled 1->0 (registered previous value) -> DONE.
REQ-027 DONE: done=1; start=1 -> ARM (wr_cnt and err cleared, memory contents kept).
REQ-028 start in ARM/RUN SHALL be ignored.
REQ-029 Readback: rb_en=1 in IDLE or DONE -> next cycle rb_valid=1, rb_data = bank[rb_sel][rb_addr] (rb_sel 0 = image); invalid sel/address -> rb_data=0, err set.
REQ-030 rb_en in ARM/RUN SHALL be ignored (rb_valid stays 0).
REQ-031 ready, done, rb_valid SHALL be registered outputs.

Reset
REQ-032 reset SHALL force state IDLE, ready=0, done=0, rb_valid=0, rb_data=0, wr_cnt=0, err=0, busy history=0.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 reset during RUN SHALL abandon the run; accelerator writes in the reset cycle dropped.

Verification
REQ-035 Load image[0]=20'h00010, image[4095]=20'hFFFF0; read iaddr=0 then 4095 -> idata 20'h00010, 20'hFFFF0 same cycle.
REQ-036 start, hold busy=0 3 cycles -> ready=1 all 3; busy=1 -> ready=0 next cycle, RUN; busy=0 -> done=1 next cycle.
REQ-037 RUN: cwr csel=3 caddr_wr=1023 data 20'h12345 -> wr_cnt=1; DONE rb_sel=3 rb_addr=1023 -> rb_data 20'h12345, rb_valid 1 cycle later.
REQ-038 RUN: cwr csel=3 caddr_wr=1024 -> err=1, wr_cnt unchanged; csel=6 crd=1 -> cdata_rd=0.
REQ-039 RUN: same-cycle cwr/crd csel=1 addr=5, old 20'h00001, new 20'h00002 -> cdata_rd 20'h00001, next cycle 20'h00002.
REQ-040 Full CONV run on loaded image -> 12288 writes, wr_cnt=12288, err=0, done=1; reset mid-RUN -> IDLE, outputs at reset values.
